ped_request_ctrl: RTL
=====================

Name: ped_request_ctrl

Overview:
- Pedestrian-button conditioner directly upstream of the traffic light controller. It drives that controller's pass_request input.
- Synchronises and debounces a raw push-button and latches the press as a pending request.
- Asserts pass_request only while the light is green with more than SHORT_THRESH seconds left, so the controller can shorten green. It then retires the request and enforces a lockout window.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level change is accepted (min 2).
- SHORT_THRESH, 10, countdown value at or below which shortening is pointless; matches the light's shortened-green load value.
- LOCKOUT_CYCLES, 32, cycles after a served request during which new presses are discarded (min 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  1  raw pedestrian button, active-high, asynchronous, bouncy
- green  in  1  registered green lamp from the light controller
- clock  in  8  countdown value from the light controller
- pass_request  out  1  shorten-green request to the light controller
- pending  out  1  a press is latched and not yet served (drives the "WAIT" lamp)
- served  out  1  one-cycle pulse when a request is retired

Behaviour:
- Reset (async, rst_n=0): sync flops=0, stable=0, debounce count=0, lockout count=0, state=IDLE. All outputs are 0 and remain 0 while rst_n=0.
- Reset mid-operation discards any pending request. No served pulse is produced.
- Synchroniser: two flops on btn_raw; sync2 equals btn_raw delayed by 2 edges.
- Debounce:
  - The counter increments each cycle that sync2 != stable.
  - The counter clears on any cycle where sync2 == stable (a bounce restarts the count).
  - On the cycle where the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and the counter clears.
  - press = stable rising (stable=1, previous stable=0). It lasts one cycle.
- FSM states: IDLE, PENDING, ASSERT, LOCKOUT. All outputs are registered (Moore):
  - pending = 1 in PENDING and ASSERT.
  - pass_request = 1 in ASSERT only.
  - served is set on the transition out of ASSERT, or out of PENDING into LOCKOUT.
- IDLE: press -> PENDING.
- PENDING:
  - green=1 and clock > SHORT_THRESH -> ASSERT.
  - green=1 and clock <= SHORT_THRESH -> LOCKOUT with served (green is already short; the request is satisfied by this green phase).
  - Otherwise stay in PENDING. Further presses are absorbed with no extra effect.
- ASSERT: leave for LOCKOUT with served on the first cycle where clock <= SHORT_THRESH or green=0. This covers the light reloading 10 and the phase ending, whichever happens first.
- LOCKOUT:
  - Loads the lockout counter with LOCKOUT_CYCLES-1 on entry and decrements it. Returns to IDLE on the cycle after the counter reads 0.
  - Presses are ignored in LOCKOUT; a press coinciding with the exit cycle is also dropped.
  - The debouncer keeps running, so a button still held after lockout does not re-trigger until it is released and pressed again.
- Comparisons: clock is treated as unsigned 8-bit, and SHORT_THRESH is compared at 8 bits.
- Latency, btn_raw rise to pending=1: 2 sync + DEBOUNCE_CYCLES + 2 (stable edge detect, state register) cycles.
- Simultaneous events:
  - A press in IDLE while green=1 and clock > SHORT_THRESH still passes through PENDING (one cycle) before ASSERT.
  - At most one state transition per cycle.
  - served must never be high in two consecutive cycles.

Decomposition:
- Shared package traffic_pkg: FSM state enumeration for this block, the SHORT_THRESH default (10), and the 8-bit countdown width constant shared with the light controller.
- Sub-module btn_debounce: synchroniser plus debounce counter plus press pulse, parameterised by DEBOUNCE_CYCLES.
- The FSM and lockout counter stay in ped_request_ctrl.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, SHORT_THRESH=10.)
- Clean press, red phase: btn_raw high at cycle 0, held; green=0 -> pending=1 at cycle 8, pass_request stays 0.
- Bouncy press: btn_raw toggles 1,0,1,0 over 4 cycles, then holds 1 -> exactly one press pulse; pending rises 8 cycles after the final rise.
- Long green: pending, then green=1 with clock=60 -> pass_request=1 the next cycle. Driving clock=10 -> pass_request=0 and served=1 the next cycle, then LOCKOUT.
- Short green: pending, green=1 with clock=7 -> no pass_request; served=1 and pending=0 the next cycle.
- Lockout: a press during LOCKOUT is ignored (pending stays 0). After 8 LOCKOUT cycles, a fresh release-and-press sets pending again.
- Reset mid-ASSERT: rst_n=0 while pass_request=1 -> pass_request, pending and served are 0 immediately (asynchronous). After release, state is IDLE with no residual request.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions between the traffic light controller and its pedestrian
// request front end.
package traffic_pkg;

  localparam int COUNT_W          = 8;
  localparam int SHORT_THRESH_DEF = 10;

  typedef enum logic [1:0] {
    PED_IDLE,
    PED_PENDING,
    PED_ASSERT,
    PED_LOCKOUT
  } pedState_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and debouncer for a bouncy push-button.
// Produces a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stablePrev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronised level matches the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stablePrev_q <= stable_q;
      press_q      <= stable_q & ~stablePrev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request conditioner: latches a debounced press and requests a
// shortened green while enough green time remains, then locks out new presses.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SHORT_THRESH    = SHORT_THRESH_DEF,
  parameter int LOCKOUT_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  input  logic               green,
  input  logic [COUNT_W-1:0] clock,
  output logic               pass_request,
  output logic               pending,
  output logic               served
);

  localparam int                 LCK_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LCK_W-1:0]   LCK_LOAD  = LCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] SHORT_LVL = COUNT_W'(SHORT_THRESH);

  logic             press;
  pedState_e        state_q;
  logic [LCK_W-1:0] lck_q;
  logic             pending_q;
  logic             passReq_q;
  logic             served_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_raw),
    .press_o(press)
  );

  // Outputs are updated together with the state so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PED_IDLE;
      lck_q     <= '0;
      pending_q <= 1'b0;
      passReq_q <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      served_q <= 1'b0;
      case (state_q)
        PED_IDLE: begin
          if (press) begin
            state_q   <= PED_PENDING;
            pending_q <= 1'b1;
          end
        end
        PED_PENDING: begin
          if (green) begin
            if (clock > SHORT_LVL) begin
              state_q   <= PED_ASSERT;
              passReq_q <= 1'b1;
            end else begin
              // Green is already short: this phase satisfies the request.
              state_q   <= PED_LOCKOUT;
              pending_q <= 1'b0;
              served_q  <= 1'b1;
              lck_q     <= LCK_LOAD;
            end
          end
        end
        PED_ASSERT: begin
          if (!green || (clock <= SHORT_LVL)) begin
            state_q   <= PED_LOCKOUT;
            pending_q <= 1'b0;
            passReq_q <= 1'b0;
            served_q  <= 1'b1;
            lck_q     <= LCK_LOAD;
          end
        end
        PED_LOCKOUT: begin
          if (lck_q == '0) begin
            state_q <= PED_IDLE;
          end else begin
            lck_q <= lck_q - 1'b1;
          end
        end
        default: begin
          state_q   <= PED_IDLE;
          pending_q <= 1'b0;
          passReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign pass_request = passReq_q;
  assign pending      = pending_q;
  assign served       = served_q;

endmodule
